bch_syndrome: RTL
=================

Name: bch_syndrome

Overview:
- Serial syndrome generator; first stage of the BCH decoder, directly downstream of the serial encoder and channel.
- Consumes a received N-bit codeword one bit per cycle, highest coefficient (x^(N-1)) first, matching encoder output order.
- Evaluates S_j = r(alpha^j) for j = 1..2T in GF(2^M) by Horner's rule.
- Presents all syndromes plus an error-present flag to the error-locator stage over a valid/ready handshake.

Parameters:
- N, 15, codeword length (data + parity bits).
- K, 5, data bits per codeword.
- T, 3, correctable errors; 2T syndromes produced.
- M (localparam), $clog2(N+2)-1, field degree; 4 for defaults.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- reset, input, 1, asynchronous, active-low; asserted when 0.
- start, input, 1, qualifies the first bit of a codeword; only meaningful with din_valid=1.
- din_valid, input, 1, din carries a codeword bit this cycle.
- din, input, 1, received bit.
- busy, output, 1, a frame is being accumulated.
- syndromes, output, 2*T*M, S_j at bits [(j-1)*M +: M], polynomial basis, bit 0 = alpha^0.
- err_present, output, 1, OR of all syndrome bits; valid only with syn_valid.
- syn_valid, output, 1, syndromes/err_present are valid.
- syn_ready, input, 1, downstream accepts the result.
- overflow, output, 1, one-cycle pulse: completed frame dropped.

Behaviour:
- Reset (reset=0, asynchronous): accumulators=0, bit counter=0, busy=0, syn_valid=0, syndromes=0, err_present=0, overflow=0.
- Accumulator j update on a cycle with din_valid=1:
  - start=1: acc_j <= {M-1 zeros, din}.
  - start=0 and busy=1: acc_j <= const_mul(acc_j, alpha^j) ^ din.
- start=1 with din_valid=1 forces counter=1 and busy=1, including mid-frame. The partial frame is discarded silently, with no overflow.
- din_valid=1, start=0, busy=0: bit ignored; state unchanged.
- din_valid=0: full stall; accumulators and counter hold.
- Frame completion: the Nth valid bit (counter reaches N) ends the frame.
  - Next edge: busy <= 0.
  - Final accumulator values (including the Nth bit) are copied into the output register, with syn_valid <= 1.
  - Latency is one cycle from the edge sampling the last bit to syn_valid high.
- A new start in the cycle immediately after the last bit is accepted. Back-to-back frames need no gap cycles.
- Output handshake:
  - syndromes, err_present and syn_valid hold stable while syn_valid=1 and syn_ready=0.
  - Transfer occurs on an edge with syn_valid=1 and syn_ready=1. syn_valid then drops unless a new frame completes on the same edge; if it does, the new result loads and syn_valid stays 1.
- Overflow: a frame completes while syn_valid=1 and syn_ready=0.
  - The held result is kept; the new result is discarded.
  - overflow=1 for exactly one cycle.
- err_present is registered together with syndromes: the OR of the loaded values.
- Arithmetic:
  - const_mul is the GF(2^M) product modulo bch_polynomial(M), built as a pure XOR network.
  - alpha^j is reduced by lpow(M, j). j up to 2T may exceed 2^M-1 only when the exponent wraps modulo 2^M-1.
- Check property: for binary codes, S_2i = S_i^2. The implementation computes all 2T syndromes directly; the bench checks the property.

Decomposition:
- Field helpers belong in the shared bch.vh include, not in this module: bch_polynomial, mul, mul1, lpow, and a new const_mul(m, a, power) constant function.
- M derivation is shared with the encoder and decoder through the same include.
- One natural sub-module: bch_syndrome_acc.
  - Parameters M and POWER.
  - Holds a single M-bit Horner accumulator with its constant multiplier.
  - Instantiated 2T times in a generate loop.
- Counter, frame control and output register stay in bch_syndrome.

Test Plan:
- All-zero codeword, N=15/K=5/T=3 -> one cycle after bit 15: syn_valid=1, all six syndromes 4'h0, err_present=0.
- Valid codeword = generator 000010100110111 (MSB first, poly x^4+x+1) -> all syndromes 0, err_present=0.
- Same codeword, last bit flipped (error at x^0) -> S1..S6 all 4'b0001, err_present=1.
- All-zero frame with a single 1 at x^1 (14th bit) -> S1..S6 = 0010, 0100, 1000, 0011, 0110, 1100.
- Two back-to-back frames with syn_ready=0 throughout:
  - First result held unchanged.
  - overflow pulses exactly one cycle at second completion.
  - Raising syn_ready then transfers the first result; syn_valid drops next cycle.
- Corner cases:
  - Random din_valid gaps give identical syndromes to the gap-free run.
  - start reasserted at bit 7 restarts the frame without overflow.
  - reset=0 mid-frame clears busy/syn_valid asynchronously, before the next clock edge.

Source files
------------

// File: rtl/bch_syndrome_pkg.sv
// -----------------------------------------------------------------------------
// bch_syndrome_pkg
// Shared GF(2^m) helpers for the BCH encoder / syndrome / decoder chain.
// All functions are constant-foldable. They are meant for elaboration-time
// use, for example to build the constant multiplier matrices in
// bch_syndrome_acc.
//   calc_m          : field degree derived from the codeword length
//   bch_polynomial  : primitive polynomial for GF(2^m), including the x^m term
//   mul1            : multiply by alpha (one shift + conditional reduction)
//   mul             : general GF(2^m) product
//   lpow            : alpha^j, exponent reduced modulo 2^m-1
//   const_mul       : a * alpha^power
// -----------------------------------------------------------------------------
package bch_syndrome_pkg;

    localparam int GF_W = 16;
    typedef logic [GF_W-1:0] gf_t;

    // Field degree: N = 2^m - 1 for a primitive BCH code.
    function automatic int calc_m(input int n);
        return $clog2(n + 2) - 1;
    endfunction

    function automatic gf_t bch_polynomial(input int m);
        gf_t p;
        case (m)
            2:       p = gf_t'('h7);
            3:       p = gf_t'('hb);
            4:       p = gf_t'('h13);
            5:       p = gf_t'('h25);
            6:       p = gf_t'('h43);
            7:       p = gf_t'('h89);
            8:       p = gf_t'('h11d);
            9:       p = gf_t'('h211);
            10:      p = gf_t'('h409);
            11:      p = gf_t'('h805);
            12:      p = gf_t'('h1053);
            13:      p = gf_t'('h201b);
            14:      p = gf_t'('h4443);
            15:      p = gf_t'('h8003);
            default: p = gf_t'('h13);
        endcase
        return p;
    endfunction

    function automatic gf_t mul1(input int m, input gf_t a);
        gf_t r;
        r = a << 1;
        if (r[m]) begin
            r = r ^ bch_polynomial(m);
        end
        return r;
    endfunction

    // Shift-and-add from the MSB of b down; loop bound fixed so it unrolls.
    function automatic gf_t mul(input int m, input gf_t a, input gf_t b);
        gf_t r;
        r = '0;
        for (int i = GF_W - 1; i >= 0; i--) begin
            if (i < m) begin
                r = mul1(m, r);
                if (b[i]) begin
                    r = r ^ a;
                end
            end
        end
        return r;
    endfunction

    function automatic gf_t lpow(input int m, input int j);
        gf_t r;
        int  e;
        e = j % ((1 << m) - 1);
        r = gf_t'(1);
        for (int i = 0; i < e; i++) begin
            r = mul1(m, r);
        end
        return r;
    endfunction

    function automatic gf_t const_mul(input int m, input gf_t a, input int power);
        return mul(m, a, lpow(m, power));
    endfunction

endpackage

// File: rtl/bch_syndrome_if.sv
// -----------------------------------------------------------------------------
// bch_syndrome_if
// Bundles the syndrome generator's serial input and its result handshake.
//   start, din_valid, din : serial codeword bits, MSB (x^(N-1)) first
//   busy                  : frame being accumulated
//   syndromes             : S_j at [(j-1)*M +: M], j = 1..2T
//   err_present           : OR of all syndrome bits, qualified by syn_valid
//   syn_valid / syn_ready : result handshake
//   overflow              : one-cycle pulse when a completed frame is dropped
// master = bit source / result consumer, slave = bch_syndrome.
// -----------------------------------------------------------------------------
interface bch_syndrome_if
    import bch_syndrome_pkg::*;
#(
    parameter int N = 15,
    parameter int T = 3
);
    localparam int M = calc_m(N);

    logic             start;
    logic             din_valid;
    logic             din;
    logic             busy;
    logic [2*T*M-1:0] syndromes;
    logic             err_present;
    logic             syn_valid;
    logic             syn_ready;
    logic             overflow;

    modport master (
        output start, din_valid, din, syn_ready,
        input  busy, syndromes, err_present, syn_valid, overflow
    );

    modport slave (
        input  start, din_valid, din, syn_ready,
        output busy, syndromes, err_present, syn_valid, overflow
    );

endinterface

// File: rtl/bch_syndrome_acc.sv
// -----------------------------------------------------------------------------
// bch_syndrome_acc
// One Horner accumulator evaluating r(alpha^POWER) over GF(2^M).
//   clk, reset    : clock, asynchronous active-low reset
//   load_i        : first bit of a frame; accumulator becomes {0.., din_i}
//   shift_i       : later bit; acc <= acc * alpha^POWER ^ din_i
//   din_i         : received bit
//   acc_next_o    : next-state value (already includes the current bit)
// -----------------------------------------------------------------------------
module bch_syndrome_acc
    import bch_syndrome_pkg::*;
#(
    parameter int M     = 4,
    parameter int POWER = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic         din_i,
    output logic [M-1:0] acc_next_o
);

    logic [M-1:0] acc_q;
    logic [M-1:0] acc_d;
    logic [M-1:0] prod;
    logic [M-1:0] term [M];

    // Column gi of the constant multiplier is alpha^gi * alpha^POWER. The
    // product is the XOR of the columns selected by the accumulator bits.
    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_col
            localparam gf_t COL = const_mul(M, gf_t'(1) << gi, POWER);
            assign term[gi] = acc_q[gi] ? COL[M-1:0] : '0;
        end
    endgenerate

    always_comb begin
        prod = '0;
        for (int i = 0; i < M; i++) begin
            prod = prod ^ term[i];
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d    = '0;
            acc_d[0] = din_i;
        end else if (shift_i) begin
            acc_d    = prod;
            acc_d[0] = prod[0] ^ din_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_next_o = acc_d;

endmodule

// File: rtl/bch_syndrome.sv
// -----------------------------------------------------------------------------
// bch_syndrome
// Serial BCH syndrome generator. It takes one received bit per cycle,
// highest coefficient first, and evaluates S_j = r(alpha^j) for j = 1..2T.
// On the edge that samples the Nth bit, it registers the syndromes and
// err_present for the downstream error-locator stage.
//   clk    : clock
//   reset  : asynchronous active-low reset
//   bus    : bch_syndrome_if.slave (serial input + result handshake)
// -----------------------------------------------------------------------------
module bch_syndrome
    import bch_syndrome_pkg::*;
#(
    parameter int N = 15,
    parameter int K = 5,
    parameter int T = 3
) (
    input  logic           clk,
    input  logic           reset,
    bch_syndrome_if.slave  bus
);

    localparam int M  = calc_m(N);
    localparam int SW = 2 * T * M;
    localparam int CW = $clog2(N + 1);

    generate
        if (K < 1 || K >= N) begin : g_bad_k
            $error("bch_syndrome: K must lie in 1..N-1");
        end
    endgenerate

    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [SW-1:0] syn_q, syn_d;
    logic          err_q, err_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic [SW-1:0] acc_next;
    logic          load;
    logic          shift;
    logic          frame_done;

    // start always opens a new frame, even mid-frame. Plain bits are only
    // taken while a frame is open.
    assign load  = bus.din_valid && bus.start;
    assign shift = bus.din_valid && !bus.start && busy_q;

    generate
        for (genvar gi = 0; gi < 2 * T; gi++) begin : g_acc
            bch_syndrome_acc #(
                .M     (M),
                .POWER (gi + 1)
            ) u_acc (
                .clk        (clk),
                .reset      (reset),
                .load_i     (load),
                .shift_i    (shift),
                .din_i      (bus.din),
                .acc_next_o (acc_next[gi*M +: M])
            );
        end
    endgenerate

    // Bit counter / frame control
    always_comb begin
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        frame_done = 1'b0;
        if (load) begin
            cnt_d  = CW'(1);
            busy_d = 1'b1;
        end else if (shift) begin
            cnt_d = cnt_q + CW'(1);
        end
        if ((load || shift) && cnt_d == CW'(N)) begin
            frame_done = 1'b1;
            busy_d     = 1'b0;
            cnt_d      = '0;
        end
    end

    // Output register. acc_next already holds the Nth bit, so the result is
    // captured on the same edge that samples it. That lets a new frame start
    // on the very next cycle.
    always_comb begin
        syn_d   = syn_q;
        err_d   = err_q;
        valid_d = valid_q;
        ovf_d   = 1'b0;
        if (frame_done && valid_q && !bus.syn_ready) begin
            ovf_d = 1'b1;
        end else if (frame_done) begin
            syn_d   = acc_next;
            err_d   = |acc_next;
            valid_d = 1'b1;
        end else if (valid_q && bus.syn_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            syn_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            syn_q   <= syn_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.syndromes   = syn_q;
    assign bus.err_present = err_q;
    assign bus.syn_valid   = valid_q;
    assign bus.overflow    = ovf_q;

endmodule
